// File: rtl/player_move_ctrl.sv
// Player movement controller: checks the target cell against the maze wall memory, then
// erases the old sprite cell and draws the new one through the VGA cell drawer.
module player_move_ctrl #(
  parameter int unsigned GRID_W  = 20,
  parameter int unsigned GRID_H  = 15,
  parameter int unsigned START_X = 1,
  parameter int unsigned START_Y = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] dir,
  output logic       map_rd_req,
  output logic [8:0] map_addr,
  input  logic       map_rd_valid,
  input  logic       map_wall,
  output logic       draw_req,
  input  logic       draw_ack,
  output logic [4:0] draw_x,
  output logic [3:0] draw_y,
  output logic       draw_erase,
  output logic [4:0] pos_x,
  output logic [3:0] pos_y,
  output logic       busy,
  output logic       blocked
);

  typedef enum logic [2:0] {StIdle, StRd, StWait, StErase, StDraw} state_e;

  state_e     state_q, state_d;
  logic [4:0] pos_x_q, pos_x_d, old_x_q, old_x_d, tx_q, tx_d;
  logic [3:0] pos_y_q, pos_y_d, old_y_q, old_y_d, ty_q, ty_d;
  logic [8:0] map_addr_q, map_addr_d;
  logic       blocked_q, blocked_d;
  // High for the first DRAW cycle so draw_req drops between the two requests.
  logic       gap_q, gap_d;

  logic [4:0] tgt_x;
  logic [3:0] tgt_y;
  logic       off_grid;

  always_comb begin
    tgt_x    = pos_x_q;
    tgt_y    = pos_y_q;
    off_grid = 1'b0;
    case (dir)
      2'b00: begin
        if (pos_y_q == 4'd0) off_grid = 1'b1;
        else                 tgt_y = pos_y_q - 4'd1;
      end
      2'b01: begin
        if (pos_x_q == 5'd0) off_grid = 1'b1;
        else                 tgt_x = pos_x_q - 5'd1;
      end
      2'b10: begin
        if (pos_y_q == 4'(GRID_H - 1)) off_grid = 1'b1;
        else                           tgt_y = pos_y_q + 4'd1;
      end
      default: begin
        if (pos_x_q == 5'(GRID_W - 1)) off_grid = 1'b1;
        else                           tgt_x = pos_x_q + 5'd1;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    old_x_d    = old_x_q;
    old_y_d    = old_y_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    map_addr_d = map_addr_q;
    blocked_d  = 1'b0;
    gap_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (tick) begin
          if (off_grid) begin
            blocked_d = 1'b1;
          end else begin
            tx_d       = tgt_x;
            ty_d       = tgt_y;
            map_addr_d = 9'((32'(tgt_y) * GRID_W) + 32'(tgt_x));
            state_d    = StRd;
          end
        end
      end
      StRd: state_d = StWait;
      StWait: begin
        if (map_rd_valid) begin
          if (map_wall) begin
            blocked_d = 1'b1;
            state_d   = StIdle;
          end else begin
            old_x_d = pos_x_q;
            old_y_d = pos_y_q;
            pos_x_d = tx_q;
            pos_y_d = ty_q;
            state_d = StErase;
          end
        end
      end
      StErase: begin
        if (draw_ack) begin
          gap_d   = 1'b1;
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (!gap_q && draw_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pos_x_q    <= 5'(START_X);
      pos_y_q    <= 4'(START_Y);
      old_x_q    <= 5'd0;
      old_y_q    <= 4'd0;
      tx_q       <= 5'd0;
      ty_q       <= 4'd0;
      map_addr_q <= 9'd0;
      blocked_q  <= 1'b0;
      gap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      old_x_q    <= old_x_d;
      old_y_q    <= old_y_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      map_addr_q <= map_addr_d;
      blocked_q  <= blocked_d;
      gap_q      <= gap_d;
    end
  end

  always_comb begin
    map_rd_req = (state_q == StRd);
    draw_erase = (state_q == StErase);
    draw_req   = (state_q == StErase) || ((state_q == StDraw) && !gap_q);
    draw_x     = 5'd0;
    draw_y     = 4'd0;
    if (state_q == StErase) begin
      draw_x = old_x_q;
      draw_y = old_y_q;
    end else if (state_q == StDraw) begin
      draw_x = pos_x_q;
      draw_y = pos_y_q;
    end
    map_addr = map_addr_q;
    pos_x    = pos_x_q;
    pos_y    = pos_y_q;
    busy     = (state_q != StIdle);
    blocked  = blocked_q;
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: one task per scenario, hand-computed expectations.
module tb_player_move_ctrl;

  logic       clock, reset, tick, map_rd_req, map_rd_valid, map_wall;
  logic       draw_req, draw_ack, draw_erase, busy, blocked;
  logic [1:0] dir;
  logic [8:0] map_addr;
  logic [4:0] draw_x, pos_x;
  logic [3:0] draw_y, pos_y;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-move observations gathered by run_move.
  int         rd_cnt, blk_cnt, busy_cycles, er_cnt, dr_cnt, draw_rises;
  int         rd_addr, er_x, er_y, dr_x, dr_y;
  bit         timed_out, er_unstable, addr_unstable;

  player_move_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .dir         (dir),
    .map_rd_req  (map_rd_req),
    .map_addr    (map_addr),
    .map_rd_valid(map_rd_valid),
    .map_wall    (map_wall),
    .draw_req    (draw_req),
    .draw_ack    (draw_ack),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .draw_erase  (draw_erase),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .busy        (busy),
    .blocked     (blocked)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Pulses tick and plays the memory and drawer responders; inputs change on negedges.
  task automatic run_move(input logic [1:0] d, input int vdelay, input int edelay,
                          input int spur, input bit wall, input bit extra);
    int cyc, since_rd, tail;
    bit rd_seen, done, prev_req;
    rd_cnt = 0; blk_cnt = 0; busy_cycles = 0; er_cnt = 0; dr_cnt = 0; draw_rises = 0;
    rd_addr = -1; er_x = -1; er_y = -1; dr_x = -1; dr_y = -1;
    timed_out = 0; er_unstable = 0; addr_unstable = 0;
    cyc = 0; since_rd = 0; tail = 0; rd_seen = 0; done = 0; prev_req = 0;
    @(negedge clock);
    dir = d; tick = 1'b1; map_wall = wall; map_rd_valid = 1'b0; draw_ack = 1'b0;
    while (tail < 3) begin
      @(negedge clock);
      tick = 1'b0;
      cyc++;
      if (rd_seen) since_rd++;
      if (map_rd_req) begin
        rd_cnt++; rd_addr = int'(map_addr); rd_seen = 1; since_rd = 0;
      end else if (rd_seen && busy && !draw_req && er_cnt == 0 && int'(map_addr) != rd_addr) begin
        addr_unstable = 1;
      end
      if (busy) busy_cycles++;
      if (blocked) blk_cnt++;
      if (draw_req && !prev_req) draw_rises++;
      prev_req = draw_req;
      if (draw_req && draw_erase) begin
        er_cnt++;
        if (er_cnt == 1) begin
          er_x = int'(draw_x); er_y = int'(draw_y);
        end else if (int'(draw_x) != er_x || int'(draw_y) != er_y) begin
          er_unstable = 1;
        end
      end
      if (draw_req && !draw_erase) begin
        dr_cnt++; dr_x = int'(draw_x); dr_y = int'(draw_y);
      end
      map_rd_valid = rd_seen && since_rd >= vdelay;
      draw_ack = (draw_req && (!draw_erase || er_cnt > edelay)) ||
                 (rd_seen && since_rd == spur && !draw_req);
      tick = extra && draw_req && draw_erase;
      if (extra) dir = 2'b10;
      if (!done && (blk_cnt > 0 || (busy_cycles > 0 && !busy))) done = 1;
      if (done) tail++;
      if (cyc >= 60) begin
        timed_out = 1; tail = 3;
      end
    end
    tick = 1'b0; map_rd_valid = 1'b0; draw_ack = 1'b0; map_wall = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b1; dir = 2'b11; map_rd_valid = 1'b1; map_wall = 1'b0;
    draw_ack = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({map_rd_req, draw_req, busy, blocked, draw_erase, map_addr, draw_x, draw_y} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rd=%b dreq=%b busy=%b blk=%b er=%b addr=%0d dx=%0d dy=%0d want all 0",
               map_rd_req, draw_req, busy, blocked, draw_erase, map_addr, draw_x, draw_y);
    end
    n_cmp++;
    if (pos_x !== 5'd1) begin n_bad++; $display("FAIL reset_pos_x: got %0d want 1", pos_x); end
    n_cmp++;
    if (pos_y !== 4'd1) begin n_bad++; $display("FAIL reset_pos_y: got %0d want 1", pos_y); end
    tick = 1'b0; map_rd_valid = 1'b0; draw_ack = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_clean_move();
    run_move(2'b11, 0, 0, -1, 1'b0, 1'b0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL clean_timeout: got 1 want 0"); end
    n_cmp++; if (rd_cnt != 1) begin n_bad++; $display("FAIL clean_rd_cnt: got %0d want 1", rd_cnt); end
    n_cmp++; if (rd_addr != 22) begin n_bad++; $display("FAIL clean_addr: got %0d want 22", rd_addr); end
    n_cmp++;
    if (er_x != 1 || er_y != 1) begin
      n_bad++; $display("FAIL clean_erase_xy: got (%0d,%0d) want (1,1)", er_x, er_y);
    end
    n_cmp++;
    if (dr_x != 2 || dr_y != 1) begin
      n_bad++; $display("FAIL clean_draw_xy: got (%0d,%0d) want (2,1)", dr_x, dr_y);
    end
    n_cmp++;
    if (pos_x !== 5'd2 || pos_y !== 4'd1) begin
      n_bad++; $display("FAIL clean_pos: got (%0d,%0d) want (2,1)", pos_x, pos_y);
    end
    n_cmp++;
    if (busy_cycles != 5) begin n_bad++; $display("FAIL clean_busy_cycles: got %0d want 5", busy_cycles); end
    n_cmp++;
    if (draw_rises != 2) begin n_bad++; $display("FAIL clean_draw_gap: got %0d rises want 2", draw_rises); end
    n_cmp++; if (blk_cnt != 0) begin n_bad++; $display("FAIL clean_blocked: got %0d want 0", blk_cnt); end
    n_cmp++;
    if (addr_unstable) begin n_bad++; $display("FAIL clean_addr_stable: got unstable want stable"); end
  endtask

  task automatic test_move_left();
    run_move(2'b01, 0, 0, -1, 1'b0, 1'b0);
    n_cmp++;
    if (timed_out || rd_addr != 21) begin
      n_bad++; $display("FAIL left_addr: got %0d (timeout=%0d) want 21", rd_addr, timed_out);
    end
    n_cmp++;
    if (er_x != 2 || dr_x != 1) begin
      n_bad++; $display("FAIL left_draw_x: got erase %0d draw %0d want erase 2 draw 1", er_x, dr_x);
    end
    n_cmp++;
    if (pos_x !== 5'd1 || pos_y !== 4'd1) begin
      n_bad++; $display("FAIL left_pos: got (%0d,%0d) want (1,1)", pos_x, pos_y);
    end
  endtask

  task automatic test_wall();
    run_move(2'b00, 0, 0, -1, 1'b1, 1'b0);
    n_cmp++;
    if (timed_out || rd_cnt != 1) begin
      n_bad++; $display("FAIL wall_rd_cnt: got %0d (timeout=%0d) want 1", rd_cnt, timed_out);
    end
    n_cmp++; if (rd_addr != 1) begin n_bad++; $display("FAIL wall_addr: got %0d want 1", rd_addr); end
    n_cmp++; if (blk_cnt != 1) begin n_bad++; $display("FAIL wall_blocked: got %0d want 1", blk_cnt); end
    n_cmp++; if (draw_rises != 0) begin n_bad++; $display("FAIL wall_no_draw: got %0d want 0", draw_rises); end
    n_cmp++;
    if (busy_cycles != 2) begin n_bad++; $display("FAIL wall_busy_cycles: got %0d want 2", busy_cycles); end
    n_cmp++;
    if (pos_x !== 5'd1 || pos_y !== 4'd1) begin
      n_bad++; $display("FAIL wall_pos: got (%0d,%0d) want (1,1)", pos_x, pos_y);
    end
  endtask

  task automatic test_off_grid();
    run_move(2'b01, 0, 0, -1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_move(2'b10, 0, 0, -1, 1'b0, 1'b0);
    n_cmp++;
    if (pos_x !== 5'd0 || pos_y !== 4'd5) begin
      n_bad++; $display("FAIL walk_pos: got (%0d,%0d) want (0,5)", pos_x, pos_y);
    end
    run_move(2'b01, 0, 0, -1, 1'b0, 1'b0);
    n_cmp++; if (rd_cnt != 0) begin n_bad++; $display("FAIL offgrid_rd: got %0d want 0", rd_cnt); end
    n_cmp++; if (blk_cnt != 1) begin n_bad++; $display("FAIL offgrid_blocked: got %0d want 1", blk_cnt); end
    n_cmp++; if (busy_cycles != 0) begin n_bad++; $display("FAIL offgrid_busy: got %0d want 0", busy_cycles); end
    n_cmp++;
    if (pos_x !== 5'd0 || pos_y !== 4'd5) begin
      n_bad++; $display("FAIL offgrid_pos: got (%0d,%0d) want (0,5)", pos_x, pos_y);
    end
  endtask

  task automatic test_ack_stall();
    run_move(2'b11, 0, 10, -1, 1'b0, 1'b1);
    n_cmp++;
    if (timed_out || rd_addr != 101) begin
      n_bad++; $display("FAIL stall_addr: got %0d (timeout=%0d) want 101", rd_addr, timed_out);
    end
    n_cmp++;
    if (er_x != 0 || er_y != 5 || er_unstable) begin
      n_bad++; $display("FAIL stall_erase: got (%0d,%0d) unstable=%0d want (0,5) stable", er_x, er_y, er_unstable);
    end
    n_cmp++; if (er_cnt != 11) begin n_bad++; $display("FAIL stall_erase_len: got %0d want 11", er_cnt); end
    n_cmp++;
    if (dr_x != 1 || dr_y != 5) begin
      n_bad++; $display("FAIL stall_draw_xy: got (%0d,%0d) want (1,5)", dr_x, dr_y);
    end
    n_cmp++;
    if (busy_cycles != 15) begin n_bad++; $display("FAIL stall_busy_cycles: got %0d want 15", busy_cycles); end
    n_cmp++;
    if (pos_x !== 5'd1 || pos_y !== 4'd5) begin
      n_bad++; $display("FAIL stall_pos: got (%0d,%0d) want (1,5)", pos_x, pos_y);
    end
  endtask

  task automatic test_reset_mid_draw();
    bit reached;
    reached = 0;
    @(negedge clock);
    dir = 2'b00; tick = 1'b1; map_rd_valid = 1'b1; map_wall = 1'b0; draw_ack = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      @(negedge clock);
      tick = 1'b0;
      draw_ack = draw_req && draw_erase;
      if (draw_req && !draw_erase) reached = 1;
    end
    n_cmp++;
    if (!reached) begin n_bad++; $display("FAIL middraw_reach: got no DRAW request want one within 20 cycles"); end
    draw_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (draw_req !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL middraw_abort: got draw_req=%b busy=%b want 0 0", draw_req, busy);
    end
    n_cmp++;
    if (pos_x !== 5'd1 || pos_y !== 4'd1) begin
      n_bad++; $display("FAIL middraw_pos: got (%0d,%0d) want (1,1)", pos_x, pos_y);
    end
    map_rd_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    draw_ack = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || draw_req !== 1'b0) begin
      n_bad++; $display("FAIL middraw_no_resume: got busy=%b draw_req=%b want 0 0", busy, draw_req);
    end
    draw_ack = 1'b0;
  endtask

  task automatic test_delayed_valid();
    run_move(2'b10, 8, 0, 3, 1'b0, 1'b0);
    n_cmp++;
    if (timed_out || rd_cnt != 1 || rd_addr != 41) begin
      n_bad++; $display("FAIL delay_addr: got cnt=%0d addr=%0d timeout=%0d want 1 41 0", rd_cnt, rd_addr, timed_out);
    end
    n_cmp++;
    if (addr_unstable) begin n_bad++; $display("FAIL delay_addr_stable: got unstable want stable"); end
    n_cmp++;
    if (er_cnt != 1 || er_x != 1 || er_y != 1) begin
      n_bad++; $display("FAIL delay_erase: got len=%0d (%0d,%0d) want 1 (1,1)", er_cnt, er_x, er_y);
    end
    n_cmp++;
    if (dr_x != 1 || dr_y != 2) begin
      n_bad++; $display("FAIL delay_draw_xy: got (%0d,%0d) want (1,2)", dr_x, dr_y);
    end
    n_cmp++;
    if (busy_cycles != 12) begin n_bad++; $display("FAIL delay_busy_cycles: got %0d want 12", busy_cycles); end
    n_cmp++;
    if (pos_x !== 5'd1 || pos_y !== 4'd2) begin
      n_bad++; $display("FAIL delay_pos: got (%0d,%0d) want (1,2)", pos_x, pos_y);
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; dir = 2'b00;
    map_rd_valid = 1'b0; map_wall = 1'b0; draw_ack = 1'b0;
    test_reset();
    test_clean_move();
    test_move_left();
    test_wall();
    test_off_grid();
    test_ack_stall();
    test_reset_mid_draw();
    test_delayed_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 Parameter GRID_W, default 20, maze width in cells.
REQ-002 Parameter GRID_H, default 15, maze height in cells.
REQ-003 Parameter START_X, default 1, reset column of the player.
REQ-004 Parameter START_Y, default 1, reset row of the player.
REQ-005 Port clock  in  1  single system clock; all state changes on its rising edge.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port tick  in  1  one-cycle move request pulse.
REQ-008 Port dir  in  2  direction of the move: 00 up, 01 left, 10 down, 11 right.
REQ-009 Port map_rd_req  out  1  one-cycle read strobe to the maze wall memory.
REQ-010 Port map_addr  out  9  cell address, computed as y*GRID_W + x.
REQ-011 Port map_rd_valid  in  1  read data valid, sampled only in state WAIT.
REQ-012 Port map_wall  in  1  1 = the addressed cell is a wall; qualified by map_rd_valid.
REQ-013 Port draw_req  out  1  draw request to the VGA cell drawer.
REQ-014 Port draw_ack  in  1  drawer accepted the request.
REQ-015 Port draw_x  out  5  cell column to draw.
REQ-016 Port draw_y  out  4  cell row to draw.
REQ-017 Port draw_erase  out  1  1 = paint background, 0 = paint player.
REQ-018 Port pos_x  out  5  current player column.
REQ-019 Port pos_y  out  4  current player row.
REQ-020 Port busy  out  1  high in every state except IDLE.
REQ-021 Port blocked  out  1  one-cycle pulse when a move is rejected.

Function
REQ-022 The FSM SHALL have the states IDLE, RD, WAIT, ERASE, DRAW.
REQ-023 IDLE: when tick=1, latch dir and compute target (tx,ty) = pos ±1 on the selected axis (up: y-1, down: y+1, left: x-1, right: x+1).
REQ-024 Off-grid target (x=0 with left, x=GRID_W-1 with right, y=0 with up, y=GRID_H-1 with down): no map read, blocked=1 on the next cycle, stay in IDLE.
REQ-025 Legal target: go to RD, with map_addr = ty*GRID_W+tx registered on the same edge.
REQ-026 RD: map_rd_req=1 for exactly one cycle, then go to WAIT; map_addr stays stable until WAIT exits.
REQ-027 WAIT: hold until map_rd_valid=1; unbounded wait; no timeout.
REQ-028 WAIT with map_wall=1: blocked=1 for one cycle, return to IDLE, pos unchanged.
REQ-029 WAIT with map_wall=0: save the old position, set pos := (tx,ty) on that edge, go to ERASE.
REQ-030 ERASE: draw_req=1, draw_x/draw_y = old pos, draw_erase=1; all held stable until draw_ack=1 is sampled; then go to DRAW.
REQ-031 DRAW: draw_req=1, draw_x/draw_y = new pos, draw_erase=0; held until draw_ack=1; then go to IDLE.
REQ-032 draw_req SHALL deassert for at least one cycle between the ERASE and DRAW requests.
REQ-033 A tick arriving while busy=1 SHALL be dropped, not queued; dir changes while busy are ignored.
REQ-034 map_rd_valid outside WAIT and draw_ack outside ERASE/DRAW SHALL be ignored.
REQ-035 A clean move takes at least 6 cycles from tick to IDLE (IDLE, RD, WAIT, ERASE, gap, DRAW) with zero-wait responders.

Reset
REQ-036 While reset=1, the FSM SHALL be in IDLE, with pos=(START_X,START_Y).
REQ-037 While reset=1, map_rd_req, draw_req, busy and blocked SHALL all be 0, and map_addr, draw_x, draw_y, draw_erase SHALL all be 0.
REQ-038 Reset asserted mid-move SHALL abort immediately, including an outstanding draw_req, with no completion of the pending draw.
REQ-039 The first tick after reset release SHALL be accepted normally.

Verification
REQ-040 Reset, then tick with dir=11, wall=0, immediate valid and ack -> map_addr=22; erase at (1,1); draw at (2,1); pos=(2,1); busy falls after DRAW ack.
REQ-041 At pos (1,1), tick with dir=00, wall=1 -> one map_rd_req with map_addr=1; blocked pulse of 1 cycle; no draw_req; pos stays (1,1).
REQ-042 Force pos (0,5), tick with dir=01 -> no map_rd_req; blocked=1 the next cycle; busy stays 0.
REQ-043 Hold draw_ack=0 for 10 cycles in ERASE -> draw_req, draw_x, draw_y, draw_erase stable throughout; extra ticks dropped; pos ends one step away.
REQ-044 Assert reset while in DRAW with draw_req=1 -> draw_req=0 asynchronously; pos=(1,1); state IDLE.
REQ-045 Delay map_rd_valid by 7 cycles, with a spurious draw_ack pulse during WAIT -> the ack is ignored; the move completes correctly.
